// File: rtl/argmax_pkg.sv
// Shared types and helpers for the sequential argmax unit.
package argmax_pkg;

  localparam int unsigned CAND_VAL_W = 64;
  localparam int unsigned CAND_IDX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Scores are sign- or zero-extended into val so a single compare serves both modes.
  typedef struct packed {
    logic [CAND_VAL_W-1:0] val;
    logic [CAND_IDX_W-1:0] idx;
  } cand_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

  function automatic logic cand_gt(input cand_t a, input cand_t b, input logic sgn);
    if (sgn) return $signed(a.val) > $signed(b.val);
    return a.val > b.val;
  endfunction

endpackage

// File: rtl/argmax_lane_reduce.sv
// Combinational reduction of one lane group into the running best (and runner-up when
// ARGMAX_TOP2_EN is defined). Lanes are folded in index order with a strict compare.
module argmax_lane_reduce
  import argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LANES       = 1,
  parameter int unsigned SIGNED      = 1
) (
  input  logic [LANES*DATA_W-1:0] lane_vals,
  input  logic [CAND_IDX_W-1:0]   base_idx,
  input  cand_t                   best_in,
  output cand_t                   best_c
`ifdef ARGMAX_TOP2_EN
  ,
  input  cand_t                   run_in,
  input  logic                    run_valid_in,
  output cand_t                   run_c,
  output logic                    run_valid_c
`endif
);

  cand_t             cand;
  cand_t             cur;
  logic [DATA_W-1:0] v;
`ifdef ARGMAX_TOP2_EN
  cand_t             run;
  logic              run_v;
`endif

  always_comb begin
    cur  = best_in;
    cand = '0;
    v    = '0;
`ifdef ARGMAX_TOP2_EN
    run   = run_in;
    run_v = run_valid_in;
`endif
    for (int unsigned l = 0; l < LANES; l++) begin
      v        = lane_vals[l*DATA_W +: DATA_W];
      cand.idx = base_idx + CAND_IDX_W'(l);
      cand.val = (SIGNED != 0) ? CAND_VAL_W'($signed(v)) : CAND_VAL_W'(v);
      // Padding lanes past the last class never participate; the seed class never meets itself.
      if ((cand.idx < CAND_IDX_W'(NUM_CLASSES)) && (cand.idx != cur.idx)) begin
        if (cand_gt(cand, cur, SIGNED != 0)) begin
`ifdef ARGMAX_TOP2_EN
          run   = cur;
          run_v = 1'b1;
`endif
          cur = cand;
        end
`ifdef ARGMAX_TOP2_EN
        else if (!run_v || cand_gt(cand, run, SIGNED != 0)) begin
          run   = cand;
          run_v = 1'b1;
        end
`endif
      end
    end
    best_c = cur;
`ifdef ARGMAX_TOP2_EN
    run_c       = run;
    run_valid_c = run_v;
`endif
  end

endmodule

// File: rtl/argmax_unit.sv
// Sequential argmax over NUM_CLASSES snapshotted scores, LANES per cycle.
// Optional macro ARGMAX_TOP2_EN adds result_2nd (runner-up index).
module argmax_unit
  import argmax_pkg::*;
#(
  parameter  int unsigned NUM_CLASSES = 10,
  parameter  int unsigned DATA_W      = 16,
  parameter  int unsigned LANES       = 1,
  parameter  int unsigned SIGNED      = 1,
  localparam int unsigned IDX_W       = clog2_min1(NUM_CLASSES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CLASSES*DATA_W-1:0] scores,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              result
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]              result_2nd
`endif
);

  localparam int unsigned STEPS    = (NUM_CLASSES + LANES - 1) / LANES;
  localparam int unsigned GRP_W    = clog2_min1(STEPS);
  localparam int unsigned GRP_BITS = LANES * DATA_W;
  localparam int unsigned PAD_W    = (STEPS * LANES - NUM_CLASSES) * DATA_W;

  state_t                          state, state_n;
  logic [NUM_CLASSES*DATA_W-1:0]   snap, snap_n;
  logic [STEPS*GRP_BITS-1:0]       snap_pad;
  logic [GRP_BITS-1:0]             lane_vals;
  logic [DATA_W-1:0]               first_val;
  cand_t                           best, best_n, red_best;
  logic [GRP_W-1:0]                group, group_n;
  logic                            busy_n, done_n;
  logic [IDX_W-1:0]                result_n;
`ifdef ARGMAX_TOP2_EN
  cand_t                           run, run_n, red_run;
  logic                            run_v, run_v_n, red_run_v;
  logic [IDX_W-1:0]                result_2nd_n;
`endif

  // Pad the snapshot to whole groups so every group slice is a constant part-select.
  generate
    if (PAD_W > 0) begin : g_pad
      assign snap_pad = {{PAD_W{1'b0}}, snap};
    end else begin : g_nopad
      assign snap_pad = snap;
    end
  endgenerate

  always_comb begin
    lane_vals = '0;
    for (int unsigned g = 0; g < STEPS; g++) begin
      if (group == GRP_W'(g)) lane_vals = snap_pad[g*GRP_BITS +: GRP_BITS];
    end
  end

  assign first_val = scores[DATA_W-1:0];

  argmax_lane_reduce #(
    .NUM_CLASSES(NUM_CLASSES),
    .DATA_W     (DATA_W),
    .LANES      (LANES),
    .SIGNED     (SIGNED)
  ) u_reduce (
    .lane_vals   (lane_vals),
    .base_idx    (CAND_IDX_W'(group) * CAND_IDX_W'(LANES)),
    .best_in     (best),
    .best_c      (red_best)
`ifdef ARGMAX_TOP2_EN
    ,
    .run_in      (run),
    .run_valid_in(run_v),
    .run_c       (red_run),
    .run_valid_c (red_run_v)
`endif
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    snap_n   = snap;
    best_n   = best;
    group_n  = group;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    result_n = result;
`ifdef ARGMAX_TOP2_EN
    run_n        = run;
    run_v_n      = run_v;
    result_2nd_n = result_2nd;
`endif
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n    = SCAN;
          snap_n     = scores;
          best_n.val = (SIGNED != 0) ? CAND_VAL_W'($signed(first_val)) : CAND_VAL_W'(first_val);
          best_n.idx = '0;
          group_n    = '0;
`ifdef ARGMAX_TOP2_EN
          run_n   = '0;
          run_v_n = 1'b0;
`endif
        end
      end
      SCAN: begin
        best_n = red_best;
`ifdef ARGMAX_TOP2_EN
        run_n   = red_run;
        run_v_n = red_run_v;
`endif
        if (group == GRP_W'(STEPS - 1)) begin
          state_n  = DONE;
          done_n   = 1'b1;
          result_n = red_best.idx[IDX_W-1:0];
`ifdef ARGMAX_TOP2_EN
          result_2nd_n = red_run_v ? red_run.idx[IDX_W-1:0] : '0;
`endif
        end else begin
          group_n = group + GRP_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap   <= '0;
      best   <= '0;
      group  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
`ifdef ARGMAX_TOP2_EN
      run        <= '0;
      run_v      <= 1'b0;
      result_2nd <= '0;
`endif
    end else begin
      snap   <= snap_n;
      best   <= best_n;
      group  <= group_n;
      busy   <= busy_n;
      done   <= done_n;
      result <= result_n;
`ifdef ARGMAX_TOP2_EN
      run        <= run_n;
      run_v      <= run_v_n;
      result_2nd <= result_2nd_n;
`endif
    end
  end

endmodule

// File: tb/tb_argmax_unit.sv
// Self-checking bench for argmax_unit: four configurations checked against a plain
// array-scan reference model with directed and randomized score vectors.
module tb_argmax_unit;

  localparam int unsigned NC = 10;
  localparam int unsigned DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC*DW-1:0] scores;
  logic [DW-1:0]   scores1;
  logic            en_a, en_b, en_c, en_d;
  logic            busy_a, busy_b, busy_c, busy_d;
  logic            done_a, done_b, done_c, done_d;
  logic [3:0]      res_a, res_b, res_c;
  logic            res_d;
`ifdef ARGMAX_TOP2_EN
  logic [3:0]      r2_a, r2_b, r2_c;
  logic            r2_d;
`endif

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  always #5 clk = ~clk;

  argmax_unit u_a (
    .clk(clk), .reset(reset), .enable(en_a), .scores(scores),
    .busy(busy_a), .done(done_a), .result(res_a)
`ifdef ARGMAX_TOP2_EN
    , .result_2nd(r2_a)
`endif
  );

  argmax_unit #(.LANES(4)) u_b (
    .clk(clk), .reset(reset), .enable(en_b), .scores(scores),
    .busy(busy_b), .done(done_b), .result(res_b)
`ifdef ARGMAX_TOP2_EN
    , .result_2nd(r2_b)
`endif
  );

  argmax_unit #(.LANES(2), .SIGNED(0)) u_c (
    .clk(clk), .reset(reset), .enable(en_c), .scores(scores),
    .busy(busy_c), .done(done_c), .result(res_c)
`ifdef ARGMAX_TOP2_EN
    , .result_2nd(r2_c)
`endif
  );

  argmax_unit #(.NUM_CLASSES(1)) u_d (
    .clk(clk), .reset(reset), .enable(en_d), .scores(scores1),
    .busy(busy_d), .done(done_d), .result(res_d)
`ifdef ARGMAX_TOP2_EN
    , .result_2nd(r2_d)
`endif
  );

  logic       busy_s, done_s;
  logic [3:0] res_s;
  logic [3:0] r2_s;

  always_comb begin
    r2_s = '0;
    case (sel)
      0: begin
        busy_s = busy_a; done_s = done_a; res_s = res_a;
`ifdef ARGMAX_TOP2_EN
        r2_s = r2_a;
`endif
      end
      1: begin
        busy_s = busy_b; done_s = done_b; res_s = res_b;
`ifdef ARGMAX_TOP2_EN
        r2_s = r2_b;
`endif
      end
      2: begin
        busy_s = busy_c; done_s = done_c; res_s = res_c;
`ifdef ARGMAX_TOP2_EN
        r2_s = r2_c;
`endif
      end
      default: begin
        busy_s = busy_d; done_s = done_d; res_s = {3'b000, res_d};
`ifdef ARGMAX_TOP2_EN
        r2_s = {3'b000, r2_d};
`endif
      end
    endcase
  end

  // Reference model: score i as a plain integer under the chosen signedness.
  function automatic longint sval(input logic [NC*DW-1:0] s, input int i, input bit sg);
    logic [DW-1:0] v;
    v = s[i*DW +: DW];
    return sg ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic int ref_max(input logic [NC*DW-1:0] s, input int n, input bit sg);
    int b;
    b = 0;
    for (int i = 1; i < n; i++) if (sval(s, i, sg) > sval(s, b, sg)) b = i;
    return b;
  endfunction

  function automatic int ref_2nd(input logic [NC*DW-1:0] s, input int n, input bit sg);
    int m, b;
    m = ref_max(s, n, sg);
    b = -1;
    for (int i = 0; i < n; i++)
      if (i != m && (b < 0 || sval(s, i, sg) > sval(s, b, sg))) b = i;
    return (b < 0) ? 0 : b;
  endfunction

  function automatic int steps_of(input int s);
    case (s)
      0: return 10;
      1: return 3;
      2: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic logic [NC*DW-1:0] rand_vec(input int mode);
    logic [NC*DW-1:0] v;
    logic [DW-1:0]    pick [4];
    pick[0] = 16'h8000; pick[1] = 16'h7FFF; pick[2] = 16'h0000; pick[3] = 16'hFFFF;
    v = '0;
    for (int i = 0; i < NC; i++) begin
      case (mode)
        0:       v[i*DW +: DW] = 16'($urandom);
        1:       v[i*DW +: DW] = 16'($urandom_range(0, 3));
        default: v[i*DW +: DW] = pick[$urandom_range(0, 3)];
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_en(input int s, input logic v);
    case (s)
      0: en_a = v;
      1: en_b = v;
      2: en_c = v;
      default: en_d = v;
    endcase
  endtask

  // One start on DUT s; optionally scramble the bus while busy to prove snapshot use.
  task automatic run_check(input int s, input logic [NC*DW-1:0] v, input string tag, input bit scramble);
    int n, cyc, exp_r;
    bit sg;
    n     = (s == 3) ? 1 : 10;
    sg    = (s != 2);
    exp_r = ref_max(v, n, sg);
    sel   = s;
    @(negedge clk);
    scores  = v;
    scores1 = v[DW-1:0];
    set_en(s, 1'b1);
    @(negedge clk);
    set_en(s, 1'b0);
    check({tag, "_busy_start"}, 64'(busy_s), 64'(1));
    cyc = 0;
    while (!done_s && cyc < 40) begin
      if (scramble) begin
        scores  = rand_vec(0);
        scores1 = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(steps_of(s)));
    check({tag, "_result"}, 64'(res_s), 64'(exp_r));
    check({tag, "_busy_done"}, 64'(busy_s), 64'(1));
`ifdef ARGMAX_TOP2_EN
    check({tag, "_result_2nd"}, 64'(r2_s), 64'(ref_2nd(v, n, sg)));
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done_s), 64'(0));
    check({tag, "_busy_end"}, 64'(busy_s), 64'(0));
    check({tag, "_held"}, 64'(res_s), 64'(exp_r));
  endtask

  logic [NC*DW-1:0] vec, vec2;
  logic [DW-1:0]    sv [NC];
  int               cyc;
  bit               seen;

  initial begin
    reset = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    scores = '0; scores1 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_done", 64'(done_a), 64'(0));
    check("rst_result", 64'(res_a), 64'(0));
    check("rst_busy_b", 64'(busy_b), 64'(0));
    reset = 1'b0;

    // Powers-of-two ladder with dominant class 0.
    sv[0] = 16'h0800; sv[1] = 16'h0000;
    for (int i = 2; i < NC; i++) sv[i] = 16'(1 << (i - 2));
    for (int i = 0; i < NC; i++) vec[i*DW +: DW] = sv[i];
    run_check(0, vec, "ladder", 1'b0);

    // All equal: lowest index wins.
    for (int i = 0; i < NC; i++) vec[i*DW +: DW] = 16'h0100;
    run_check(0, vec, "ties", 1'b0);
    run_check(1, vec, "ties_l4", 1'b0);

    // Sign-sensitive vector.
    vec = '0;
    vec[3*DW +: DW] = 16'h8000;
    vec[9*DW +: DW] = 16'h0001;
    run_check(2, vec, "unsigned", 1'b0);
    check("unsigned_is3", 64'(res_c), 64'(3));
    run_check(0, vec, "signed", 1'b0);
    check("signed_is9", 64'(res_a), 64'(9));

    // Partial last group with LANES=4.
    vec = '0;
    vec[9*DW +: DW] = 16'h7FFF;
    vec[8*DW +: DW] = 16'h7FFE;
    run_check(1, vec, "lanes4", 1'b0);

    // Single class.
    run_check(3, rand_vec(0), "one_class", 1'b1);

    // Reset during the second SCAN cycle.
    sel = 0;
    vec = rand_vec(0);
    @(negedge clk);
    scores = vec; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy_a), 64'(0));
    check("midrst_done", 64'(done_a), 64'(0));
    check("midrst_result", 64'(res_a), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    check("midrst_no_done", 64'(seen), 64'(0));
    run_check(0, rand_vec(0), "after_rst", 1'b1);

    // Enable held high on the LANES=2 unsigned unit: back-to-back runs every 7 cycles.
    sel = 2;
    vec = '0; vec2 = '0;
    for (int i = 0; i < NC; i++) begin
      vec[i*DW +: DW]  = 16'($urandom_range(0, 16'h0FFF));
      vec2[i*DW +: DW] = 16'($urandom_range(0, 16'h0FFF));
    end
    vec[0*DW +: DW]  = 16'h9000;
    vec2[5*DW +: DW] = 16'hF000;
    @(negedge clk);
    scores = vec; en_c = 1'b1;
    @(negedge clk);
    scores = vec2;
    cyc = 0;
    while (!done_c && cyc < 40) begin @(negedge clk); cyc++; end
    check("held_latency", 64'(cyc), 64'(5));
    check("held_first", 64'(res_c), 64'(ref_max(vec, 10, 1'b0)));
    @(negedge clk);
    cyc = 1;
    while (!done_c && cyc < 40) begin @(negedge clk); cyc++; end
    check("held_period", 64'(cyc), 64'(7));
    check("held_second", 64'(res_c), 64'(ref_max(vec2, 10, 1'b0)));
    check("held_second_is5", 64'(res_c), 64'(5));
    en_c = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized runs across all configurations.
    for (int k = 0; k < 24; k++) begin
      run_check(k % 4, rand_vec(int'($urandom_range(0, 2))), "rand", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/argmax_unit.md
Name: argmax_unit

Overview:
Parametrised sequential argmax for classifier output scores. It is the successor to the fixed 10x16-bit comparator and sits after the final FC layer.
- Snapshots NUM_CLASSES scores on start.
- Scans them LANES per cycle and reports the winning class index with a done pulse.
- Adds over the old block: configurable width, class count and lane count, signed/unsigned mode, a busy flag and deterministic tie-breaking.

Parameters:
NUM_CLASSES, 10, number of scores compared (>=1)
DATA_W, 16, bits per score
LANES, 1, scores compared per scan cycle (1..NUM_CLASSES)
SIGNED, 1, 1 = two's-complement compare, 0 = unsigned
IDX_W, derived localparam = max(1, clog2(NUM_CLASSES)), width of result

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  start request, level-sampled in IDLE only
scores  in  NUM_CLASSES*DATA_W  flat score bus; class i at bits [i*DATA_W +: DATA_W]
busy  out  1  high while SCAN or DONE
done  out  1  one-cycle pulse: result valid
result  out  IDX_W  index of the maximum score, held until the next start

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; busy=0, done=0, result=0; snapshot and best registers cleared.
- Definition: S = ceil(NUM_CLASSES/LANES).
- IDLE:
  - enable=1 at an edge: snapshot scores, best_val=class 0, best_idx=0, group=0, go to SCAN.
  - enable=0: stay in IDLE.
- SCAN:
  - Each edge compares lane candidates group*LANES .. group*LANES+LANES-1 against best.
  - Lanes with index >= NUM_CLASSES are masked (partial last group).
  - Replace best only on a strictly greater value, so ties keep the lowest index.
  - Within a group, lanes are reduced in index order under the same strict rule.
  - After S compare edges, go to DONE.
- DONE: done=1 for exactly one cycle; result is updated at the same edge done rises; next edge goes to IDLE.
- Latency: enable sampled at edge 0 -> done high during the cycle after edge S.
  - Earliest restart sample is edge S+2.
  - With enable held high, done pulses every S+2 cycles.
- While busy:
  - enable is ignored.
  - scores may change freely; the snapshot alone is used.
- Comparison: SIGNED=1 uses $signed compare; SIGNED=0 uses unsigned compare. No arithmetic; widths are preserved.
- Corner cases:
  - NUM_CLASSES=1: result=0, S=1.
  - LANES=NUM_CLASSES: single-cycle scan.
- Reset mid-SCAN/DONE: abort, all outputs to reset values, no done pulse.

Optional Feature:
Macro ARGMAX_TOP2_EN.
- Defined:
  - Adds output result_2nd (IDX_W) = index of the largest score excluding result, with ties going to the lowest index.
  - Requires runner-up tracking: a new candidate beating best demotes the old best to runner-up; otherwise the candidate competes for runner-up.
  - NUM_CLASSES=1 gives result_2nd=0.
  - Same timing and reset as result.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package argmax_pkg holds:
  - state enum (IDLE, SCAN, DONE);
  - function clog2_min1 for IDX_W;
  - a typedef for the (value, index) candidate pair.
- Sub-module argmax_lane_reduce is natural: combinational reduction of LANES masked candidates plus the incoming best to the new best (and runner-up under ARGMAX_TOP2_EN).
- argmax_unit owns the FSM, snapshot, group counter and output registers.

Test Plan:
- Default params; scores = {0x0800,0,1,2,4,8,0x10,0x20,0x40,0x80}; enable after reset -> done exactly 10 cycles after the enable-sample edge, result=0; with TOP2, result_2nd=9.
- All ten scores 0x0100 -> result=0; with TOP2, result_2nd=1.
- Class 3=0x8000, class 9=0x0001, rest 0 -> SIGNED=1 gives result=9; SIGNED=0 gives result=3.
- NUM_CLASSES=10, LANES=4, max at class 9 (0x7FFF), class 8=0x7FFF-1 -> result=9, done 3 cycles after start (masked lanes 10/11 never win, even with garbage scores bus of zero).
- Reset asserted during the 2nd SCAN cycle -> busy, done and result drop to 0 immediately; no done pulse follows; next enable gives a correct fresh result.
- enable held high; scores change to max at class 5 one cycle after start -> first result=0 (snapshot); done repeats every 7 cycles; the second run gives result=5.
